// File: rtl/fwd_sched_if.sv
// fwd_sched_if: request/abort inputs and schedule outputs of the forward-pass scheduler
//   go, abort                  : inference request / cancel (driven by the requester)
//   start_0, start_1           : stream-request pulses to the weight store
//   row_valid_x, row_idx_x     : current row of layer x is on the weight bus
//   last_x                     : final row of layer x
//   acc_clr, busy, done        : accumulator clear, activity flag, completion pulse
interface fwd_sched_if;
    logic       go;
    logic       abort;
    logic       start_0;
    logic       start_1;
    logic       row_valid_0;
    logic       row_valid_1;
    logic [9:0] row_idx_0;
    logic [6:0] row_idx_1;
    logic       last_0;
    logic       last_1;
    logic       acc_clr;
    logic       busy;
    logic       done;
    modport master (
        input  go, abort,
        output start_0, start_1, row_valid_0, row_valid_1, row_idx_0, row_idx_1,
               last_0, last_1, acc_clr, busy, done
    );
    modport slave (
        output go, abort,
        input  start_0, start_1, row_valid_0, row_valid_1, row_idx_0, row_idx_1,
               last_0, last_1, acc_clr, busy, done
    );
endinterface

// File: rtl/fwd_sched.sv
// fwd_sched: sequences the layer-0 and layer-1 weight streams of one inference
//   clka  : clock
//   rst_n : asynchronous active-low reset
//   bus   : fwd_sched_if master (go/abort in, start/row/last/acc_clr/busy/done out)
module fwd_sched #(
    parameter int L0_ROWS = 784,
    parameter int L1_ROWS = 128,
    parameter int GAP     = 2
) (
    input  logic clka,
    input  logic rst_n,
    fwd_sched_if.master bus
);
    localparam int MR = L0_ROWS > L1_ROWS ? (L0_ROWS > 16 ? L0_ROWS : 16) : (L1_ROWS > 16 ? L1_ROWS : 16);
    localparam int CW = $clog2(MR + 1);
    localparam logic [CW-1:0] LAST0 = CW'(L0_ROWS - 1);
    localparam logic [CW-1:0] LAST1 = CW'(L1_ROWS - 1);
    localparam logic [CW-1:0] GLAST = CW'(GAP - 1);

    typedef enum logic [2:0] {IDLE, L0_ISSUE, L0_RUN, GAP_WAIT, L1_ISSUE, L1_RUN, FIN, FLUSH} state_t;

    state_t        state, nstate;
    logic [CW-1:0] cnt, ncnt;
    logic          fl1, nfl1;
    logic          v0, v1;

    // The counter keeps running through FLUSH so the store's stream is
    // allowed to drain before a new start pulse can be issued.
    always_comb begin
        nstate = state;
        ncnt   = '0;
        nfl1   = fl1;
        case (state)
            IDLE:     nstate = bus.go ? L0_ISSUE : IDLE;
            L0_ISSUE: nstate = L0_RUN;
            L0_RUN: begin
                nfl1 = 1'b0;
                ncnt = cnt + 1'b1;
                if (bus.abort) nstate = FLUSH;
                else if (cnt == LAST0) begin
                    nstate = GAP_WAIT;
                    ncnt   = '0;
                end
            end
            GAP_WAIT: begin
                ncnt = cnt + 1'b1;
                if (bus.abort) begin
                    nstate = IDLE;
                    ncnt   = '0;
                end else if (cnt == GLAST) begin
                    nstate = L1_ISSUE;
                    ncnt   = '0;
                end
            end
            L1_ISSUE: nstate = L1_RUN;
            L1_RUN: begin
                nfl1 = 1'b1;
                ncnt = cnt + 1'b1;
                if (bus.abort) nstate = FLUSH;
                else if (cnt == LAST1) begin
                    nstate = FIN;
                    ncnt   = '0;
                end
            end
            FIN: nstate = IDLE;
            FLUSH: begin
                ncnt = cnt + 1'b1;
                if (cnt >= (fl1 ? LAST1 : LAST0)) begin
                    nstate = IDLE;
                    ncnt   = '0;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    assign v0 = nstate == L0_RUN;
    assign v1 = nstate == L1_RUN;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            fl1             <= 1'b0;
            bus.start_0     <= 1'b0;
            bus.start_1     <= 1'b0;
            bus.row_valid_0 <= 1'b0;
            bus.row_valid_1 <= 1'b0;
            bus.row_idx_0   <= '0;
            bus.row_idx_1   <= '0;
            bus.last_0      <= 1'b0;
            bus.last_1      <= 1'b0;
            bus.acc_clr     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            state           <= nstate;
            cnt             <= ncnt;
            fl1             <= nfl1;
            bus.start_0     <= nstate == L0_ISSUE;
            bus.start_1     <= nstate == L1_ISSUE;
            bus.row_valid_0 <= v0;
            bus.row_valid_1 <= v1;
            bus.row_idx_0   <= v0 ? 10'(ncnt) : '0;
            bus.row_idx_1   <= v1 ? 7'(ncnt) : '0;
            bus.last_0      <= v0 && ncnt == LAST0;
            bus.last_1      <= v1 && ncnt == LAST1;
            bus.acc_clr     <= nstate == L0_ISSUE || nstate == L1_ISSUE;
            bus.busy        <= nstate != IDLE;
            bus.done        <= nstate == FIN;
        end
    end
endmodule

// File: tb/tb_fwd_sched.sv
// tb_fwd_sched: directed checks of fwd_sched at default and small parameters
module tb_fwd_sched;
    localparam int N0 = 784, N1 = 128, G = 2;
    localparam int S0 = 4, S1 = 3, SG = 1;
    localparam logic [25:0] BUSY = 26'h40000;

    logic clka = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    fwd_sched_if ifd ();
    fwd_sched_if ifs ();

    fwd_sched dut (.clka(clka), .rst_n(rst_n), .bus(ifd));
    fwd_sched #(.L0_ROWS(S0), .L1_ROWS(S1), .GAP(SG)) dus (.clka(clka), .rst_n(rst_n), .bus(ifs));

    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {start_0,start_1,rv0,rv1,last_0,last_1,acc_clr,busy,done,row_idx_0,row_idx_1}
    function automatic logic [25:0] obs(input bit s);
        return s ? {ifs.start_0, ifs.start_1, ifs.row_valid_0, ifs.row_valid_1, ifs.last_0, ifs.last_1,
                    ifs.acc_clr, ifs.busy, ifs.done, ifs.row_idx_0, ifs.row_idx_1}
                 : {ifd.start_0, ifd.start_1, ifd.row_valid_0, ifd.row_valid_1, ifd.last_0, ifd.last_1,
                    ifd.acc_clr, ifd.busy, ifd.done, ifd.row_idx_0, ifd.row_idx_1};
    endfunction

    // Nominal timeline; t=0 is the cycle right after the edge that sampled go.
    function automatic logic [25:0] nom(input int t, input int n0, input int n1, input int g);
        int a;
        logic v0, v1;
        logic [9:0] i0;
        logic [6:0] i1;
        a  = n0 + g + 1;
        v0 = t >= 1 && t <= n0;
        v1 = t > a && t <= a + n1;
        i0 = v0 ? 10'(t - 1) : '0;
        i1 = v1 ? 7'(t - a - 1) : '0;
        return {t == 0, t == a, v0, v1, t == n0, t == a + n1, t == 0 || t == a,
                t <= a + n1 + 1, t == a + n1 + 1, i0, i1};
    endfunction

    task automatic step;
        @(posedge clka);
        #1;
    endtask

    task automatic go_pulse(input bit s);
        if (s) ifs.go = 1'b1;
        else ifd.go = 1'b1;
        step();
        ifs.go = 1'b0;
        ifd.go = 1'b0;
    endtask

    task automatic scan(input bit s, input string tag, input int n0, input int n1, input int g,
                        input int t0, input int t1);
        for (int t = t0; t <= t1; t++) begin
            check($sformatf("%s t=%0d", tag, t), 32'(obs(s)), 32'(nom(t, n0, n1, g)));
            step();
        end
    endtask

    initial begin
        ifd.go = 1'b0;
        ifd.abort = 1'b0;
        ifs.go = 1'b0;
        ifs.abort = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_d", 32'(obs(0)), 0);
        check("rst_s", 32'(obs(1)), 0);
        step();
        step();
        check("rst_hold", 32'(obs(0)), 0);
        rst_n = 1'b1;
        // small parameters: full cycle-by-cycle timeline
        go_pulse(1);
        scan(1, "small", S0, S1, SG, 0, S0 + SG + S1 + 4);
        // abort ignored in L0_ISSUE, then abort on last layer-0 row
        go_pulse(1);
        ifs.abort = 1'b1;
        check("ab_issue t=0", 32'(obs(1)), 32'(nom(0, S0, S1, SG)));
        step();
        ifs.abort = 1'b0;
        scan(1, "ab_issue", S0, S1, SG, 1, S0 - 1);
        check("ab_last t=4", 32'(obs(1)), 32'(nom(S0, S0, S1, SG)));
        ifs.abort = 1'b1;
        step();
        ifs.abort = 1'b0;
        check("ab_last flush", 32'(obs(1)), 32'(BUSY));
        step();
        for (int t = 0; t < 3; t++) begin
            check($sformatf("ab_last idle %0d", t), 32'(obs(1)), 0);
            step();
        end
        // abort on first layer-1 row
        go_pulse(1);
        scan(1, "ab_l1", S0, S1, SG, 0, S0 + SG + 1);
        check("ab_l1 t=7", 32'(obs(1)), 32'(nom(S0 + SG + 2, S0, S1, SG)));
        ifs.abort = 1'b1;
        step();
        ifs.abort = 1'b0;
        for (int t = S0 + SG + 3; t <= S0 + SG + 6; t++) begin
            check($sformatf("ab_l1 t=%0d", t), 32'(obs(1)), t <= S0 + SG + 4 ? 32'(BUSY) : 0);
            step();
        end
        // default parameters: nominal run
        go_pulse(0);
        scan(0, "nom", N0, N1, G, 0, N0 + G + N1 + 4);
        // go held high: one inference, next one right after IDLE
        ifd.go = 1'b1;
        step();
        scan(0, "held", N0, N1, G, 0, N0 + G + N1 + 3);
        check("held restart", 32'(obs(0)), 32'(nom(0, N0, N1, G)));
        ifd.go = 1'b0;
        for (int i = 0; i < 2000 && ifd.busy; i++) step();
        check("drain", 32'(ifd.busy), 0);
        step();
        // abort at row_idx_0 = 100
        go_pulse(0);
        scan(0, "ab0", N0, N1, G, 0, 100);
        check("ab0 t=101", 32'(obs(0)), 32'(nom(101, N0, N1, G)));
        ifd.abort = 1'b1;
        step();
        ifd.abort = 1'b0;
        for (int t = 102; t <= N0 + G + N1 + 4; t++) begin
            check($sformatf("ab0 t=%0d", t), 32'(obs(0)), t <= N0 ? 32'(BUSY) : 0);
            step();
        end
        go_pulse(0);
        scan(0, "ab0_after", N0, N1, G, 0, N0 + G + N1 + 3);
        // abort in GAP_WAIT
        go_pulse(0);
        scan(0, "abg", N0, N1, G, 0, N0);
        check("abg gap", 32'(obs(0)), 32'(nom(N0 + 1, N0, N1, G)));
        ifd.abort = 1'b1;
        step();
        ifd.abort = 1'b0;
        for (int t = N0 + 2; t <= N0 + G + N1 + 4; t++) begin
            check($sformatf("abg t=%0d", t), 32'(obs(0)), 0);
            step();
        end
        // asynchronous reset at row_idx_1 = 50
        go_pulse(0);
        scan(0, "rstm", N0, N1, G, 0, N0 + G + 51);
        check("rstm row50", 32'(obs(0)), 32'(nom(N0 + G + 52, N0, N1, G)));
        #2 rst_n = 1'b0;
        #1;
        check("rstm async", 32'(obs(0)), 0);
        step();
        step();
        check("rstm hold", 32'(obs(0)), 0);
        rst_n = 1'b1;
        go_pulse(0);
        scan(0, "rstm_after", N0, N1, G, 0, N0 + G + N1 + 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
